// File: rtl/sc_clk_burst_ctrl_if.sv
// Handshake/pin bundle between the config/readout FSM (master) and the SC_clk burst sequencer (slave).
// The serial-data signals exist only when SC_SHIFT_EN is defined.
interface sc_clk_burst_ctrl_if #(
    parameter int CNT_W  = 26,
    parameter int NP_W   = 16
`ifdef SC_SHIFT_EN
    ,
    parameter int DATA_W = 32
`endif
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] half_div;
    logic [NP_W-1:0]  n_pulse;
    logic             clk_o;
    logic             rise_stb;
    logic             busy;
    logic             done;
`ifdef SC_SHIFT_EN
    logic [DATA_W-1:0] sdata_in;
    logic              sdo;

    modport master (
        output start, abort, half_div, n_pulse, sdata_in,
        input  clk_o, rise_stb, busy, done, sdo
    );
    modport slave (
        input  start, abort, half_div, n_pulse, sdata_in,
        output clk_o, rise_stb, busy, done, sdo
    );
`else
    modport master (
        output start, abort, half_div, n_pulse,
        input  clk_o, rise_stb, busy, done
    );
    modport slave (
        input  start, abort, half_div, n_pulse,
        output clk_o, rise_stb, busy, done
    );
`endif
endinterface

// File: rtl/sc_clk_burst_ctrl.sv
// SC_clk burst sequencer: emits n_pulse divided clock pulses on clk_o, then reports done.
// Optional serial data shifter (sdata_in -> sdo, MSB first) enabled by defining SC_SHIFT_EN.
module sc_clk_burst_ctrl #(
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 83333,
    parameter int NP_W     = 16
`ifdef SC_SHIFT_EN
    ,
    parameter int DATA_W   = 32
`endif
) (
    input  logic                  clki,
    input  logic                  rst_n,
    sc_clk_burst_ctrl_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);

    logic [1:0]       state;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt;
    logic [NP_W-1:0]  pcnt;
    logic             clk_q;
    logic             rise_q;
    logic             busy_q;
    logic             done_q;

    logic phase_end;
    logic start_burst;
    logic abort_burst;
    logic last_pulse;

    assign phase_end   = (cnt == half_q - CNT_W'(1));
    assign start_burst = (state == S_IDLE) && bus.start && !bus.abort && (bus.n_pulse != '0);
    assign abort_burst = (state != S_IDLE) && bus.abort;
    assign last_pulse  = (pcnt == NP_W'(1));

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every state register is reset here; this block holds no memory arrays, so nothing is left undefined.
            state  <= S_IDLE;
            half_q <= '0;
            cnt    <= '0;
            pcnt   <= '0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later defaults-then-overrides read as one edge.
            rise_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.n_pulse == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            half_q <= (bus.half_div == '0) ? DEF_HALF_C : bus.half_div;
                            pcnt   <= bus.n_pulse;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (abort_burst) begin
                        cnt    <= '0;
                        clk_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (phase_end) begin
                        cnt    <= '0;
                        clk_q  <= 1'b1;
                        rise_q <= 1'b1;
                        state  <= S_HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (abort_burst) begin
                        cnt    <= '0;
                        clk_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (phase_end) begin
                        cnt   <= '0;
                        clk_q <= 1'b0;
                        pcnt  <= pcnt - NP_W'(1);
                        if (last_pulse) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_LOW;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    clk_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.clk_o    = clk_q;
    assign bus.rise_stb = rise_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef SC_SHIFT_EN
    logic [DATA_W-1:0] sreg;

    // Shift on every falling edge but the last, so bit i is stable across rising edge i.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (start_burst) begin
            sreg <= bus.sdata_in;
        end else if (abort_burst) begin
            sreg <= '0;
        end else if (state == S_HIGH && phase_end && !last_pulse) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
        end
    end

    assign bus.sdo = sreg[DATA_W-1];
`else
    logic unused_start;
    assign unused_start = start_burst;
`endif

endmodule

// File: tb/tb_sc_clk_burst_ctrl.sv
// Self-checking bench for sc_clk_burst_ctrl: table-driven burst vectors plus hand sequences
// for abort, async reset and (with SC_SHIFT_EN) serial data.
module tb_sc_clk_burst_ctrl;

    localparam int CNT_W = 26;
    localparam int NP_W  = 16;

    logic clki;
    logic rst_n;

    sc_clk_burst_ctrl_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();

    sc_clk_burst_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_HALF(5),
        .NP_W    (NP_W)
    ) dut (
        .clki (clki),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {bus.clk_o, bus.rise_stb, bus.busy, bus.done};
    endfunction

    // exp = {clk_o, rise_stb, busy, done} after the edge the row's inputs are sampled on
    typedef struct {
        bit         st;
        bit         ab;
        int         hd;
        int         np;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit st, input bit ab, input int hd, input int np,
                       input logic [3:0] e, input string nm);
        vec_t v;
        v.st = st; v.ab = ab; v.hd = hd; v.np = np; v.exp = e; v.name = nm;
        vq.push_back(v);
    endtask

    initial begin
        int rises;
        int dones;
        int busys;
        int cyc;
        bit seen;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.half_div = '0;
        bus.n_pulse  = '0;
`ifdef SC_SHIFT_EN
        bus.sdata_in = '0;
`endif
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
        repeat (2) @(posedge clki);
        @(negedge clki);
        rst_n = 1'b1;

        // half=2, N=3; a start with new settings mid-burst must not disturb it
        add(1, 0, 2, 3, 4'b0010, "t1_start");
        add(0, 0, 2, 3, 4'b0010, "t1_c1");
        add(0, 0, 2, 3, 4'b1110, "t1_rise0");
        add(0, 0, 2, 3, 4'b1010, "t1_c3");
        add(1, 0, 7, 9, 4'b0010, "t1_fall0_ignstart");
        add(0, 0, 2, 3, 4'b0010, "t1_c5");
        add(0, 0, 2, 3, 4'b1110, "t1_rise1");
        add(0, 0, 2, 3, 4'b1010, "t1_c7");
        add(0, 0, 2, 3, 4'b0010, "t1_fall1");
        add(0, 0, 2, 3, 4'b0010, "t1_c9");
        add(0, 0, 2, 3, 4'b1110, "t1_rise2");
        add(0, 0, 2, 3, 4'b1010, "t1_c11");
        add(0, 0, 2, 3, 4'b0001, "t1_done");
        add(0, 0, 2, 3, 4'b0000, "t1_idle");
        // n_pulse=0: done only
        add(1, 0, 2, 0, 4'b0001, "t3_zero_done");
        add(0, 0, 2, 0, 4'b0000, "t3_idle");
        // abort with start in IDLE: abort wins
        add(1, 1, 2, 3, 4'b0000, "abort_start_idle");
        add(0, 0, 2, 3, 4'b0000, "abort_idle_after");
        // half_div=0 selects DEF_HALF=5, N=1
        add(1, 0, 0, 1, 4'b0010, "t2_start");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 4'b0010, "t2_low");
        add(0, 0, 0, 1, 4'b1110, "t2_rise");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 4'b1010, "t2_high");
        add(0, 0, 0, 1, 4'b0001, "t2_done");
        add(0, 0, 0, 1, 4'b0000, "t2_idle");

        foreach (vq[i]) begin
            bus.start    = vq[i].st;
            bus.abort    = vq[i].ab;
            bus.half_div = CNT_W'(vq[i].hd);
            bus.n_pulse  = NP_W'(vq[i].np);
            step();
            check(vq[i].name, 32'(outs()), 32'(vq[i].exp));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // half=3, N=4: start pulse while busy, abort one cycle after the first rise
        bus.half_div = CNT_W'(3);
        bus.n_pulse  = NP_W'(4);
        bus.start    = 1'b1;
        step();
        check("t4_busy", 32'(bus.busy), 32'h1);
        step();
        bus.start = 1'b0;
        step();
        step();
        check("t4_rise", 32'(outs()), 32'b1110);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4_abort", 32'(outs()), 32'b0000);
        rises = 0; dones = 0; busys = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            rises += int'(bus.rise_stb);
            dones += int'(bus.done);
            busys += int'(bus.busy);
        end
        check("t4_no_done", 32'(dones), 32'h0);
        check("t4_no_restart", 32'(rises + busys), 32'h0);

        // async reset in HIGH phase, then a fresh full burst (half=1, N=2)
        bus.half_div = CNT_W'(2);
        bus.n_pulse  = NP_W'(3);
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("t5_in_high", 32'(bus.clk_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async", 32'(outs()), 32'b0000);
        @(negedge clki);
        rst_n = 1'b1;
        bus.half_div = CNT_W'(1);
        bus.n_pulse  = NP_W'(2);
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        rises = 0; cyc = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            rises += int'(bus.rise_stb);
            if (bus.done) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        check("t5_done_cycle", 32'(cyc), 32'd4);
        check("t5_rises", 32'(rises), 32'd2);

`ifdef SC_SHIFT_EN
        begin
            logic [7:0] bits;
            bits = '0;
            bus.sdata_in = 32'hA500_0000;
            bus.half_div = CNT_W'(1);
            bus.n_pulse  = NP_W'(8);
            bus.start    = 1'b1;
            step();
            bus.start = 1'b0;
            rises = 0; cyc = 0; seen = 1'b0;
            for (int i = 1; i <= 40 && !seen; i++) begin
                step();
                if (bus.rise_stb) begin
                    bits  = {bits[6:0], bus.sdo};
                    rises++;
                end
                if (bus.done) begin
                    seen = 1'b1;
                    cyc  = i;
                end
            end
            check("t6_sdo_bits", 32'(bits), 32'hA5);
            check("t6_rises", 32'(rises), 32'd8);
            check("t6_done_cycle", 32'(cyc), 32'd16);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
